audio_pll_reset_sequencer: RTL

Power-up and recovery sequencer for the 18.432 MHz audio PLL. Holds the PLL in reset for a fixed interval, waits for lock with a timeout, requires lock to stay stable, then releases the audio-domain reset. Re-sequences automatically on lock loss and latches a fault after repeated failures. Runs on the 50 MHz reference clock and sits between the board reset and the PLL plus audio codec logic.

---
 rtl/audio_pll_seq_pkg.sv | 26 ++
 rtl/audio_pll_lock_sync.sv | 24 ++
 rtl/audio_pll_reset_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/audio_pll_seq_pkg.sv
// Shared types and sizing helpers for the audio PLL reset sequencer.
package audio_pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } seq_state_e;

   localparam int unsigned LLC_W   = 8;
   localparam int unsigned LLC_MAX = 255;

   // Width of the shared down-counter: enough bits to hold the largest load value.
   function automatic int unsigned cnt_w(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/audio_pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
module audio_pll_lock_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/audio_pll_reset_sequencer.sv
// Power-up / recovery sequencer for the audio PLL: PLL reset, lock wait with
// timeout, lock stability qualification, audio reset release and fault latching.
module audio_pll_reset_sequencer
   import audio_pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES          = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                                 refclk,
   input  logic                                 rst,
   input  logic                                 pll_locked,
   input  logic                                 restart,
   output logic                                 pll_rst,
   output logic                                 audio_rst,
   output logic                                 ready,
   output logic                                 fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
   output logic [7:0]                           lock_loss_cnt
);

   localparam int unsigned CNT_W = cnt_w(RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int unsigned RC_W  = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RETRY_LAST   = RC_W'(MAX_RETRIES - 1);
   localparam logic [LLC_W-1:0] LLC_SAT      = LLC_W'(LLC_MAX);

   logic lk;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RC_W-1:0]  retry_q, retry_d;
   logic [LLC_W-1:0] llc_q, llc_d;
   logic             pll_rst_q, pll_rst_d;
   logic             audio_rst_q, audio_rst_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic             fail;

   audio_pll_lock_sync u_lock_sync (
      .clk_i   (refclk),
      .rst_i   (rst),
      .async_i (pll_locked),
      .sync_o  (lk)
   );

   // State, counter and output registers.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= ST_RESET;
         cnt_q       <= RST_LOAD;
         retry_q     <= '0;
         llc_q       <= '0;
         pll_rst_q   <= 1'b1;
         audio_rst_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         llc_q       <= llc_d;
         pll_rst_q   <= pll_rst_d;
         audio_rst_q <= audio_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they register
   // on the same edge as the transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      llc_d   = llc_q;
      fail    = 1'b0;

      if (restart) begin
         state_d = ST_RESET;
         cnt_d   = RST_LOAD;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (cnt_q == '0) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = TIMEOUT_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lk) begin
                  state_d = ST_STABLE;
                  cnt_d   = STABLE_LOAD;
               end else if (cnt_q == '0) begin
                  fail = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!lk) begin
                  fail = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d = ST_RUN;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state_d = ST_RESET;
                  cnt_d   = RST_LOAD;
                  if (llc_q != LLC_SAT) llc_d = llc_q + LLC_W'(1);
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_RESET;
               cnt_d   = RST_LOAD;
            end
         endcase

         // A failed attempt either retries from RESET or latches FAULT.
         if (fail) begin
            retry_d = retry_q + RC_W'(1);
            if (retry_q == RETRY_LAST) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_RESET;
               cnt_d   = RST_LOAD;
            end
         end
      end

      pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
      audio_rst_d = (state_d != ST_RUN);
      ready_d     = (state_d == ST_RUN);
      fault_d     = (state_d == ST_FAULT);
   end

   assign pll_rst       = pll_rst_q;
   assign audio_rst     = audio_rst_q;
   assign ready         = ready_q;
   assign fault         = fault_q;
   assign retry_count   = retry_q;
   assign lock_loss_cnt = llc_q;

endmodule
